sort_host: RTL and testbench
============================

Name: sort_host

Overview:
- Initiator for the toggle-command array sorter. Accepts a framed input stream, clears the sorter and loads it with PUSH toggles, then issues SORT.
- After the sort it unloads results with POP toggles onto a framed output stream.
- Sits between a valid/ready data source/sink and the sorter's clear/push/pop/sort, rx_data/tx_data, idle/full/empty port set.

Parameters:
- A_D_MSB, 7: data MSB; word width A_D_MSB+1.
- A_P_MSB, 3: sorter pointer-stack MSB. Sorter address MSB is AM = 2**A_P_MSB-1. Capacity is 2**(AM+1)-1 words (255 at default).
- WDT_CYC, 4096: idle-wait watchdog limit in cycles. Used only with SORT_HOST_WDT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  global enable, shared with the sorter
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&in_ready
- in_data  in  A_D_MSB+1  input word
- in_last  in  1  last word of frame
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts output word
- out_data  out  A_D_MSB+1  sorted word
- out_last  out  1  last word of output frame
- busy  out  1  frame in progress (state != ST_IDLE)
- ovf  out  1  sticky: words dropped because sorter was full; cleared at next frame start
- err  out  1  sticky watchdog error (tied 0 without SORT_HOST_WDT_EN); cleared at next frame start
- clear, push, pop, sort  out  1 each  toggle commands to sorter
- rx_data  out  A_D_MSB+1  word presented with push
- tx_data  in  A_D_MSB+1  sorter pop result
- idle, full, empty  in  1 each  sorter status

Behaviour:
Reset:
- All outputs 0, including toggles and rx_data.
- State ST_IDLE; count=0.

Clock and enable:
- Everything is clocked on posedge clk with async clear on negedge rstn.
- enable=0: all registers hold and no toggle changes; in_ready=0; out_valid holds.

Command rule:
- A command is a single registered inversion of one toggle line. Only one command is outstanding at a time.
- After any toggle the FSM enters its wait state.
- Wait cycle 1 is a guard: idle is ignored (stale).
- From wait cycle 2 onward, the FSM stays until idle=1, then advances.
- Minimum turnaround is 3 cycles per command.

FSM:
- ST_IDLE: in_ready=0. On in_valid=1: toggle clear, clear ovf/err/count, go ST_CLRW.
- ST_CLRW: wait rule, then go ST_LOAD.
- ST_LOAD: in_ready=1.
  - On accept with full=0 and count<capacity: rx_data<=in_data, toggle push, count+1, go ST_PUSHW; remember in_last.
  - On accept when full=1: word dropped, ovf<=1. If in_last, go ST_SORT; otherwise stay and drain.
- ST_PUSHW: wait rule. Then go ST_SORT if the remembered last flag is set, else ST_LOAD.
- ST_SORT: if count<=1, skip to ST_POP. Else toggle sort, go ST_SORTW.
- ST_SORTW: wait rule, then go ST_POP.
- ST_POP: toggle pop, go ST_POPW.
- ST_POPW: wait rule. Then out_data<=tx_data, out_valid<=1, out_last<=(count==1), count-1, go ST_EMIT.
- ST_EMIT: hold out_valid/out_data until out_ready. Then out_valid<=0, out_last<=0; go ST_IDLE if count==0, else ST_POP.

Output order:
- The sorter pops from the top, so output order is non-increasing (largest first).
- Word count out equals words stored (capacity-limited).

Boundaries:
- Frame of 1 word: no sort toggle is issued.
- A word arriving exactly at capacity is dropped and sets ovf.
- in_valid outside ST_LOAD is back-pressured.
- Reset mid-frame aborts immediately; the next frame's clear resynchronises the sorter's toggle detectors.

Optional Feature:
Macro SORT_HOST_WDT_EN.
- Defined: a counter runs in every wait state.
  - If idle is not seen within WDT_CYC cycles: err<=1, out_valid<=0, go ST_IDLE.
  - Stored data is discarded.
- Undefined: wait states have no limit; err is constant 0.

Test Plan:
- Frame 5,3,9,1,7 (last on 7), out_ready=1 -> out 9,7,5,3,1; out_last only with 1; ovf=0; exactly one clear, five push, one sort and five pop toggles.
- Single word 0x42 with in_last -> no sort toggle; out 0x42 with out_last=1; busy falls the cycle after the handshake.
- 257 words 0..256 mod 256 -> 255 stored, ovf=1, 255 words output in non-increasing order.
- out_ready held 0 for 10 cycles mid-emit -> out_data/out_valid stable; no pop toggle until acceptance.
- enable=0 for 4 cycles during ST_PUSHW -> no state or toggle change; completes normally afterwards.
- With SORT_HOST_WDT_EN and WDT_CYC=16, idle forced 0 after sort -> err=1 within 17 cycles, state ST_IDLE; rstn pulse mid-frame -> all outputs 0.

Source files
------------

// File: rtl/sort_host_if.sv
// -----------------------------------------------------------------------------
// sort_host_if -- command/status bundle between sort_host and the toggle-command
// array sorter.
//
//   master (sort_host side):
//     clear, push, pop, sort  out  toggle commands; each inversion is one command
//     rx_data                 out  word presented with a push
//     tx_data                 in   word returned by a pop
//     idle, full, empty       in   sorter status
//   slave (sorter side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface sort_host_if #(
  parameter int A_D_MSB = 7
);
  logic             clear;
  logic             push;
  logic             pop;
  logic             sort;
  logic [A_D_MSB:0] rx_data;
  logic [A_D_MSB:0] tx_data;
  logic             idle;
  logic             full;
  logic             empty;

  modport master (
    output clear, push, pop, sort, rx_data,
    input  tx_data, idle, full, empty
  );

  modport slave (
    input  clear, push, pop, sort, rx_data,
    output tx_data, idle, full, empty
  );
endinterface

// File: rtl/sort_host.sv
// -----------------------------------------------------------------------------
// sort_host -- initiator for the toggle-command array sorter.
//
// Takes one framed input stream (valid/ready/last), clears the sorter, loads
// each word with a PUSH toggle, issues SORT, then unloads with POP toggles onto
// a framed output stream, largest word first.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   enable             global enable shared with the sorter; 0 freezes all state
//   in_valid/in_ready/in_data/in_last     input frame
//   out_valid/out_ready/out_data/out_last output frame
//   busy               a frame is in progress
//   ovf                sticky: words dropped because the sorter was full
//   err                sticky: watchdog expired waiting for idle
//   srt                sorter command/status bundle (sort_host_if.master)
//
// Build option: define SORT_HOST_WDT_EN to add an idle-wait watchdog of WDT_CYC
// cycles. Without it wait states are unbounded and err is tied to 0.
// -----------------------------------------------------------------------------
module sort_host #(
  parameter int A_D_MSB = 7,
  parameter int A_P_MSB = 3,
  parameter int WDT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_D_MSB:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_D_MSB:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             ovf,
  output logic             err,
  sort_host_if.master      srt
);

  // Sorter address MSB; capacity is 2**(AM+1)-1, i.e. an all-ones counter.
  localparam int AM    = 2**A_P_MSB - 1;
  localparam int CNT_W = AM + 1;
  localparam logic [CNT_W-1:0] CAP = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLRW, ST_LOAD, ST_PUSHW, ST_SORT,
    ST_SORTW, ST_POP, ST_POPW, ST_EMIT
  } state_t;

  state_t           r_state, w_state;
  logic             r_guard, w_guard;   // first wait cycle: idle still stale
  logic [CNT_W-1:0] r_cnt,   w_cnt;
  logic             r_last,  w_last;
  logic             r_clear, w_clear;
  logic             r_push,  w_push;
  logic             r_pop,   w_pop;
  logic             r_sort,  w_sort;
  logic [A_D_MSB:0] r_rx_data, w_rx_data;
  logic             r_out_valid, w_out_valid;
  logic [A_D_MSB:0] r_out_data,  w_out_data;
  logic             r_out_last,  w_out_last;
  logic             r_ovf,   w_ovf;
  logic             w_wait_done;

`ifdef SORT_HOST_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  logic             r_err,   w_err;
  logic [WDT_W-1:0] r_wdt,   w_wdt;
  logic             w_in_wait;
`endif

  assign w_wait_done = !r_guard && srt.idle;

  always_comb begin
    // NOTE: every next-value starts as a hold of its register so no path
    // through the case statement can leave one unassigned (no latches).
    w_state     = r_state;
    w_guard     = 1'b0;      // guard lives exactly one cycle after a toggle
    w_cnt       = r_cnt;
    w_last      = r_last;
    w_clear     = r_clear;
    w_push      = r_push;
    w_pop       = r_pop;
    w_sort      = r_sort;
    w_rx_data   = r_rx_data;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_last  = r_out_last;
    w_ovf       = r_ovf;
`ifdef SORT_HOST_WDT_EN
    w_err       = r_err;
    w_wdt       = '0;
`endif

    unique case (r_state)
      ST_IDLE: if (in_valid) begin
        w_clear = ~r_clear;
        w_ovf   = 1'b0;
`ifdef SORT_HOST_WDT_EN
        w_err   = 1'b0;
`endif
        w_cnt   = '0;
        w_guard = 1'b1;
        w_state = ST_CLRW;
      end
      ST_CLRW: if (w_wait_done) w_state = ST_LOAD;
      ST_LOAD: if (in_valid) begin
        if (!srt.full && r_cnt != CAP) begin
          w_rx_data = in_data;
          w_push    = ~r_push;
          w_cnt     = r_cnt + 1'b1;
          w_last    = in_last;
          w_guard   = 1'b1;
          w_state   = ST_PUSHW;
        end else begin
          // Sorter full: keep draining the frame, flag the loss.
          w_ovf = 1'b1;
          if (in_last) w_state = ST_SORT;
        end
      end
      ST_PUSHW: if (w_wait_done) w_state = r_last ? ST_SORT : ST_LOAD;
      ST_SORT: begin
        if (r_cnt == '0) begin
          w_state = ST_IDLE;                  // nothing stored, nothing to emit
        end else if (r_cnt == CNT_W'(1)) begin
          w_state = ST_POP;                   // one word is already sorted
        end else begin
          w_sort  = ~r_sort;
          w_guard = 1'b1;
          w_state = ST_SORTW;
        end
      end
      ST_SORTW: if (w_wait_done) w_state = ST_POP;
      ST_POP: begin
        w_pop   = ~r_pop;
        w_guard = 1'b1;
        w_state = ST_POPW;
      end
      ST_POPW: if (w_wait_done) begin
        w_out_data  = srt.tx_data;
        w_out_valid = 1'b1;
        w_out_last  = (r_cnt == CNT_W'(1));
        w_cnt       = r_cnt - 1'b1;
        w_state     = ST_EMIT;
      end
      ST_EMIT: if (out_ready) begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_state     = (r_cnt == '0) ? ST_IDLE : ST_POP;
      end
      default: w_state = ST_IDLE;
    endcase

`ifdef SORT_HOST_WDT_EN
    // Watchdog: counts every wait cycle (guard included) until idle shows up.
    if (w_in_wait && !w_wait_done) begin
      if (r_wdt == WDT_W'(WDT_CYC - 1)) begin
        w_err       = 1'b1;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_cnt       = '0;
        w_state     = ST_IDLE;
      end else begin
        w_wdt = r_wdt + 1'b1;
      end
    end
`endif
  end

`ifdef SORT_HOST_WDT_EN
  assign w_in_wait = (r_state == ST_CLRW) || (r_state == ST_PUSHW) ||
                     (r_state == ST_SORTW) || (r_state == ST_POPW);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_guard     <= 1'b0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_clear     <= 1'b0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_sort      <= 1'b0;
      r_rx_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef SORT_HOST_WDT_EN
      r_err       <= 1'b0;
      r_wdt       <= '0;
`endif
    end else if (enable) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the values from before this edge.
      r_state     <= w_state;
      r_guard     <= w_guard;
      r_cnt       <= w_cnt;
      r_last      <= w_last;
      r_clear     <= w_clear;
      r_push      <= w_push;
      r_pop       <= w_pop;
      r_sort      <= w_sort;
      r_rx_data   <= w_rx_data;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_last  <= w_out_last;
      r_ovf       <= w_ovf;
`ifdef SORT_HOST_WDT_EN
      r_err       <= w_err;
      r_wdt       <= w_wdt;
`endif
    end
  end

  assign in_ready    = (r_state == ST_LOAD) && enable;
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign ovf         = r_ovf;
  assign srt.clear   = r_clear;
  assign srt.push    = r_push;
  assign srt.pop     = r_pop;
  assign srt.sort    = r_sort;
  assign srt.rx_data = r_rx_data;
`ifdef SORT_HOST_WDT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_host.sv
// -----------------------------------------------------------------------------
// tb_sort_host -- self-checking bench for sort_host.
// A behavioural sorter (queue + random busy latency) answers the toggle
// commands; expected output frames are the stored words sorted descending.
// -----------------------------------------------------------------------------
module tb_sort_host;
`ifdef SORT_HOST_WDT_EN
  localparam int WDT = 16;
`else
  localparam int WDT = 4096;
`endif
  localparam int CAP = 255;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy, ovf, err;

  int n_tests = 0;
  int n_fail  = 0;

  sort_host_if #(.A_D_MSB(7)) srt ();

  sort_host #(.A_D_MSB(7), .A_P_MSB(3), .WDT_CYC(WDT)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ovf(ovf), .err(err), .srt(srt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural sorter ----------------
  logic [7:0] sq[$];
  logic       p_clear = 1'b0, p_push = 1'b0, p_pop = 1'b0, p_sort = 1'b0;
  logic       m_idle = 1'b1, m_full = 1'b0, m_empty = 1'b1;
  logic [7:0] m_tx = '0;
  int         m_lat = 0;
  bit         m_hang = 0;
  bit         hang_arm = 0;
  int         n_clear = 0, n_push = 0, n_pop = 0, n_sort = 0;

  assign srt.idle    = m_idle;
  assign srt.full    = m_full;
  assign srt.empty   = m_empty;
  assign srt.tx_data = m_tx;

  always @(posedge clk) begin
    if (enable) begin
      bit cmd;
      cmd = 0;
      if (srt.clear != p_clear) begin sq.delete(); m_hang = 0; n_clear++; cmd = 1; end
      if (srt.push != p_push) begin
        if (sq.size() < CAP) sq.push_back(srt.rx_data);
        n_push++; cmd = 1;
      end
      if (srt.sort != p_sort) begin sq.sort(); n_sort++; cmd = 1; if (hang_arm) m_hang = 1; end
      if (srt.pop != p_pop) begin
        if (sq.size() > 0) m_tx <= sq.pop_back();
        n_pop++; cmd = 1;
      end
      p_clear <= srt.clear;
      p_push  <= srt.push;
      p_pop   <= srt.pop;
      p_sort  <= srt.sort;
      if (cmd) m_lat = $urandom_range(1, 4);
      else if (m_lat > 0) m_lat--;
      m_idle  <= (m_lat == 0) && !m_hang;
      m_full  <= (sq.size() >= CAP);
      m_empty <= (sq.size() == 0);
    end
  end

  // ---------------- sink and monitor ----------------
  bit ready_rand = 0;
  bit ready_force = 1;
  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  logic [7:0] got_q[$];
  bit         got_last[$];
  always @(negedge clk)
    if (rstn && enable && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last.push_back(out_last);
    end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic last);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("in_ready timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w[$]);
    got_q.delete(); got_last.delete();
    for (int i = 0; i < w.size(); i++) push_word(w[i], i == w.size() - 1);
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] w[$]);
    logic [7:0] exp[$];
    bit done;
    int lcnt, lpos;
    done = 0;
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    check({tag, " done"}, 32'(done), 1);
    for (int i = 0; i < w.size() && i < CAP; i++) exp.push_back(w[i]);
    exp.rsort();
    check({tag, " count"}, got_q.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s word%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp[i]));
    lcnt = 0; lpos = -1;
    foreach (got_last[i]) if (got_last[i]) begin lcnt++; lpos = i; end
    check({tag, " last_cnt"}, lcnt, 1);
    check({tag, " last_pos"}, lpos, exp.size() - 1);
  endtask

  task automatic rand_words(output logic [7:0] w[$], input int n);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back(8'($urandom));
  endtask

  initial begin
    #800000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] w[$];
    int c0, p0, s0, k0;
    logic [7:0] d0;
    logic [15:0] snap;
    bit ok, held;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", {out_valid, out_last, busy, ovf, err, in_ready, out_data}, 0);
    check("rst_cmd", {srt.clear, srt.push, srt.pop, srt.sort, srt.rx_data}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic five-word frame
    c0 = n_clear; k0 = n_push; s0 = n_sort; p0 = n_pop;
    w = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7};
    send_frame(w);
    finish_frame("t1", w);
    check("t1 ovf", ovf, 0);
    check("t1 clears", n_clear - c0, 1);
    check("t1 pushes", n_push - k0, 5);
    check("t1 sorts", n_sort - s0, 1);
    check("t1 pops", n_pop - p0, 5);

    // Single word: no sort, busy drops right after the handshake
    s0 = n_sort; p0 = n_pop;
    got_q.delete(); got_last.delete();
    push_word(8'h42, 1'b1);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    check("t2 out_valid seen", 32'(ok), 1);
    check("t2 data", out_data, 8'h42);
    check("t2 last", out_last, 1);
    check("t2 busy_before", busy, 1);
    @(negedge clk);
    check("t2 busy_after", {busy, out_valid}, 0);
    check("t2 sorts", n_sort - s0, 0);
    check("t2 pops", n_pop - p0, 1);

    // Overflow: 257 words, 255 stored
    w.delete();
    for (int i = 0; i < 257; i++) w.push_back(8'(i));
    send_frame(w);
    finish_frame("t3", w);
    check("t3 ovf", ovf, 1);

    // Output back-pressure
    ready_force = 0;
    rand_words(w, 6);
    send_frame(w);
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    check("t4 out_valid seen", 32'(ok), 1);
    check("t4 ovf cleared", ovf, 0);
    d0 = out_data; p0 = n_pop; held = 1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data != d0) held = 0;
    end
    check("t4 stall stable", 32'(held), 1);
    check("t4 stall pops", n_pop - p0, 0);
    ready_force = 1;
    finish_frame("t4", w);

    // enable=0 during a push wait
    rand_words(w, 5);
    got_q.delete(); got_last.delete();
    push_word(w[0], 1'b0);
    push_word(w[1], 1'b0);
    enable = 1'b0;
    snap = {busy, out_valid, in_ready, srt.clear, srt.push, srt.pop, srt.sort, 1'b0, srt.rx_data};
    k0 = n_push; held = 1;
    repeat (4) begin
      @(negedge clk);
      if ({busy, out_valid, in_ready, srt.clear, srt.push, srt.pop, srt.sort, 1'b0, srt.rx_data} != snap)
        held = 0;
    end
    check("t5 frozen", 32'(held), 1);
    check("t5 pushes frozen", n_push - k0, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 2; i < 5; i++) push_word(w[i], i == 4);
    finish_frame("t5", w);

    // Random frames with random output back-pressure
    ready_rand = 1;
    for (int f = 0; f < 4; f++) begin
      rand_words(w, $urandom_range(1, 30));
      send_frame(w);
      finish_frame($sformatf("rnd%0d", f), w);
    end
    ready_rand = 0;

`ifdef SORT_HOST_WDT_EN
    // Watchdog: sorter never returns to idle after SORT
    hang_arm = 1;
    rand_words(w, 3);
    s0 = 32'(srt.sort);
    send_frame(w);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (32'(srt.sort) != s0) begin ok = 1; break; end
    end
    check("t7 sort seen", 32'(ok), 1);
    ok = 0;
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      if (err) begin ok = 1; break; end
    end
    check("t7 err", 32'(ok), 1);
    @(negedge clk);
    check("t7 idle", {busy, out_valid}, 0);
    hang_arm = 0;
`endif

    // Reset in mid-frame, then a clean frame
    rand_words(w, 3);
    for (int i = 0; i < 3; i++) push_word(w[i], 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t8 rst_out", {out_valid, out_last, busy, ovf, err, in_ready, out_data}, 0);
    check("t8 rst_cmd", {srt.clear, srt.push, srt.pop, srt.sort, srt.rx_data}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    rand_words(w, 4);
    send_frame(w);
    finish_frame("t8", w);
    check("t8 err", err, 0);
    check("t8 ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
